layer_sched: RTL and testbench
==============================

// Module: layer_sched
// PURPOSE
//  Multi-layer sequencer in front of tiny_dnn_top. Holds up to N_LAYER layer descriptors written
//  by the host and, after start, walks each layer through weight load, bias load and run phases,
//  driving the mode levels (wwrite/bwrite/run/backprop/enbias) and shape fields (ss..kw).
//  Phase completion is detected by monitoring src/dst stream handshakes; no data passes through.
// PARAMETERS
//  N_LAYER  8   descriptor table depth (layers per sequence), power of 2
//  F_NUM    16  bias words per bias phase (one per core)
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous active-low reset
//  cfg_we      in   1   descriptor write strobe
//  cfg_addr    in   log2(N_LAYER)+2  {layer, word[1:0]}
//  cfg_wdata   in   32  descriptor word
//  cfg_err     out  1   1-cycle pulse: cfg_we while busy (write dropped)
//  num_layers  in   log2(N_LAYER)+1  layers to execute, 1..N_LAYER; sampled on start
//  start       in   1   1-cycle start pulse; ignored while busy
//  abort       in   1   synchronous abort, any state
//  busy        out  1   high from cycle after accepted start until done
//  done        out  1   1-cycle pulse after last layer's run phase
//  cur_layer   out  log2(N_LAYER)  layer being processed
//  src_valid/src_ready/dst_valid/dst_ready/dst_last  in 1 each  monitored handshakes
//  wwrite,bwrite,run,backprop,enbias  out 1 each  mode levels to datapath
//  ss,id,is,ih,iw,ds,od,os,oh,ow,fs,ks,kh,kw  out  12,4,10,5,5,12,4,10,5,5,10,10,5,5  shape fields
// BEHAVIOUR
//  Descriptor: w0={od[31:28],id[27:24],ds[23:12],ss[11:0]}; w1={2'b0,fs[29:20],os[19:10],is[9:0]};
//   w2={2'b0,ow[29:25],oh[24:20],iw[19:15],ih[14:10],ks[9:0]};
//   w3={enbias[31],backprop[30],8'b0,wcnt[21:10],kw[9:5],kh[4:0]}; wcnt = weight words (0 = skip).
//  Reset: state IDLE; all outputs 0; table contents undefined (not reset).
//  States: IDLE, WLOAD, BLOAD, RUN, GAP, FIN.
//  IDLE: start -> latch num_layers (0 treated as 1), cur_layer=0, GAP (next=WLOAD).
//  GAP: one cycle, all mode levels 0, shape fields already showing cur_layer; then enter the
//   pending phase, skipping WLOAD if wcnt==0 and BLOAD if enbias==0.
//  WLOAD: wwrite=1; counts src_valid&src_ready beats; on beat wcnt -> GAP (next BLOAD/RUN).
//  BLOAD: bwrite=1; on beat F_NUM -> GAP (next RUN).
//  RUN: run=1; backprop/enbias from descriptor; on dst_valid&dst_ready&dst_last -> if last layer
//   FIN else cur_layer+1, GAP (next WLOAD).
//  FIN: done=1 one cycle, busy=0, -> IDLE. Shape fields hold last layer values.
//  Mode levels are registered: change only on state transition; exactly one of wwrite/bwrite/run
//   high at a time; backprop/enbias valid only in RUN (0 elsewhere).
//  Beat counter 12 bit, cleared on every GAP; beats while in GAP/IDLE/FIN are ignored.
//  abort: next cycle IDLE, modes 0, busy 0, no done; abort wins over start and completion.
//  cfg_we in IDLE writes table next cycle; cfg_we and start same cycle: write lands, start uses it.
//  rst_n deassert mid-phase: asynchronous return to reset values; sequence not resumed.
// TESTING
//  1 layer, wcnt=3, enbias=0: start, 3 src beats, dst_last -> wwrite 3 beats, GAP, run, done once.
//  2 layers, L1 enbias=1 wcnt=0: after L0 run, bwrite for 16 beats, GAP, run; cur_layer 0->1.
//  src_valid with src_ready=0 stalls: wwrite held, count advances only on accepted beats.
//  cfg_we while busy -> cfg_err pulse, table unchanged (readback via re-run shape fields).
//  abort during BLOAD beat 7 -> IDLE next cycle, bwrite=0, done never asserted; restart works.
//  num_layers=0 -> behaves as 1; start while busy ignored; async rst_n mid-RUN clears all outputs.

Source files
------------

// File: rtl/layer_sched.sv
// Multi-layer sequencer: walks host-written layer descriptors through weight load,
// bias load and run phases, watching stream handshakes to detect phase completion.
module layer_sched #(
  parameter int N_LAYER = 8,
  parameter int F_NUM   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [$clog2(N_LAYER)+1:0]     cfg_addr,
  input  logic [31:0]                    cfg_wdata,
  output logic                           cfg_err,
  input  logic [$clog2(N_LAYER):0]       num_layers,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(N_LAYER)-1:0]     cur_layer,
  input  logic                           src_valid,
  input  logic                           src_ready,
  input  logic                           dst_valid,
  input  logic                           dst_ready,
  input  logic                           dst_last,
  output logic                           wwrite,
  output logic                           bwrite,
  output logic                           run,
  output logic                           backprop,
  output logic                           enbias,
  output logic [11:0]                    ss,
  output logic [3:0]                     id,
  output logic [9:0]                     is,
  output logic [4:0]                     ih,
  output logic [4:0]                     iw,
  output logic [11:0]                    ds,
  output logic [3:0]                     od,
  output logic [9:0]                     os,
  output logic [4:0]                     oh,
  output logic [4:0]                     ow,
  output logic [9:0]                     fs,
  output logic [9:0]                     ks,
  output logic [4:0]                     kh,
  output logic [4:0]                     kw
);

  localparam int AW = $clog2(N_LAYER);
  localparam logic [AW:0] NL_ONE = 1;
  localparam logic [AW:0] NL_MAX = N_LAYER[AW:0];
  localparam logic [11:0] FNUM12 = F_NUM[11:0];

  typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_BLOAD, S_RUN, S_GAP, S_FIN} state_e;

  state_e      state_q;
  state_e      pend_q;
  logic [11:0] cnt_q;
  logic [11:0] wcnt_q;
  logic        enb_q;
  logic        bp_q;
  logic [AW:0] nl_q;

  logic [31:0]   tbl_q [N_LAYER*4];
  logic [31:0]   ld_w [4];
  logic [AW-1:0] ld_layer;
  logic          wr_en;
  logic          beat;
  logic          last_beat;
  logic          is_last;
  logic          ld_en;
  logic          unused_bits;

  assign wr_en     = cfg_we & ~busy;
  assign beat      = src_valid & src_ready;
  assign last_beat = dst_valid & dst_ready & dst_last;
  assign is_last   = ({1'b0, cur_layer} == (nl_q - NL_ONE));
  assign ld_layer  = (state_q == S_IDLE) ? '0 : cur_layer + 1'b1;
  assign ld_en     = ~abort & (((state_q == S_IDLE) & start) |
                               ((state_q == S_RUN) & last_beat & ~is_last));

  always_ff @(posedge clk) begin
    if (wr_en) tbl_q[cfg_addr] <= cfg_wdata;
  end

  // A write landing on the same edge as start must be seen by layer 0, so forward it.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      ld_w[k] = tbl_q[{ld_layer, k[1:0]}];
      if (wr_en && (cfg_addr == {ld_layer, k[1:0]})) ld_w[k] = cfg_wdata;
    end
  end

  assign unused_bits = ^{ld_w[1][31:30], ld_w[2][31:30], ld_w[3][29:22]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pend_q    <= S_WLOAD;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      enb_q     <= 1'b0;
      bp_q      <= 1'b0;
      nl_q      <= NL_ONE;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_layer <= '0;
      wwrite    <= 1'b0;
      bwrite    <= 1'b0;
      run       <= 1'b0;
      backprop  <= 1'b0;
      enbias    <= 1'b0;
      {ss, id, is, ih, iw, ds, od} <= '0;
      {os, oh, ow, fs, ks, kh, kw} <= '0;
    end else begin
      cfg_err <= cfg_we & busy;
      done    <= 1'b0;
      if (ld_en) begin
        cur_layer          <= ld_layer;
        {od, id, ds, ss}   <= ld_w[0];
        {fs, os, is}       <= ld_w[1][29:0];
        {ow, oh, iw, ih, ks} <= ld_w[2][29:0];
        {kw, kh}           <= ld_w[3][9:0];
        wcnt_q             <= ld_w[3][21:10];
        enb_q              <= ld_w[3][31];
        bp_q               <= ld_w[3][30];
      end
      if (abort) begin
        state_q  <= S_IDLE;
        busy     <= 1'b0;
        wwrite   <= 1'b0;
        bwrite   <= 1'b0;
        run      <= 1'b0;
        backprop <= 1'b0;
        enbias   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (num_layers == '0)        nl_q <= NL_ONE;
              else if (num_layers > NL_MAX) nl_q <= NL_MAX;
              else                          nl_q <= num_layers;
              busy    <= 1'b1;
              pend_q  <= S_WLOAD;
              cnt_q   <= '0;
              state_q <= S_GAP;
            end
          end
          S_GAP: begin
            cnt_q <= '0;
            // Empty phases are skipped here so no extra gap cycle is spent on them.
            if ((pend_q == S_WLOAD) && (wcnt_q != '0)) begin
              wwrite  <= 1'b1;
              state_q <= S_WLOAD;
            end else if ((pend_q != S_RUN) && enb_q) begin
              bwrite  <= 1'b1;
              state_q <= S_BLOAD;
            end else begin
              run      <= 1'b1;
              backprop <= bp_q;
              enbias   <= enb_q;
              state_q  <= S_RUN;
            end
          end
          S_WLOAD: begin
            if (beat) begin
              cnt_q <= cnt_q + 12'd1;
              if ((cnt_q + 12'd1) == wcnt_q) begin
                wwrite  <= 1'b0;
                pend_q  <= S_BLOAD;
                state_q <= S_GAP;
              end
            end
          end
          S_BLOAD: begin
            if (beat) begin
              cnt_q <= cnt_q + 12'd1;
              if ((cnt_q + 12'd1) == FNUM12) begin
                bwrite  <= 1'b0;
                pend_q  <= S_RUN;
                state_q <= S_GAP;
              end
            end
          end
          S_RUN: begin
            if (last_beat) begin
              run      <= 1'b0;
              backprop <= 1'b0;
              enbias   <= 1'b0;
              pend_q   <= S_WLOAD;
              if (is_last) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                state_q <= S_FIN;
              end else begin
                state_q <= S_GAP;
              end
            end
          end
          S_FIN:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_sched.sv
// Scoreboard bench for layer_sched: expected mode/status transitions are queued as each
// sequence is launched and popped whenever the observed output vector changes.
module tb_layer_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_err;
  logic [3:0]  num_layers = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [2:0]  cur_layer;
  logic        src_valid = 1'b0, src_ready = 1'b0;
  logic        dst_valid = 1'b0, dst_ready = 1'b0, dst_last = 1'b0;
  logic        wwrite, bwrite, run, backprop, enbias;
  logic [11:0] ss, ds;
  logic [3:0]  id, od;
  logic [9:0]  is, os, fs, ks;
  logic [4:0]  ih, iw, oh, ow, kh, kw;

  layer_sched #(.N_LAYER(8), .F_NUM(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .num_layers(num_layers), .start(start), .abort(abort), .busy(busy),
    .done(done), .cur_layer(cur_layer), .src_valid(src_valid), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_last(dst_last), .wwrite(wwrite),
    .bwrite(bwrite), .run(run), .backprop(backprop), .enbias(enbias), .ss(ss), .id(id),
    .is(is), .ih(ih), .iw(iw), .ds(ds), .od(od), .os(os), .oh(oh), .ow(ow), .fs(fs),
    .ks(ks), .kh(kh), .kw(kw)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] ss; logic [3:0] id; logic [9:0] is; logic [4:0] ih; logic [4:0] iw;
    logic [11:0] ds; logic [3:0] od; logic [9:0] os; logic [4:0] oh; logic [4:0] ow;
    logic [9:0]  fs; logic [9:0] ks; logic [4:0] kh; logic [4:0] kw;
    logic [11:0] wcnt; logic enb; logic bp;
  } desc_t;

  int n_run = 0;
  int n_fail = 0;
  logic [9:0] exp_q [$];
  logic [9:0] prev_v = '0;
  bit         mon_en = 1'b0;
  desc_t L0, L1, L0b;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mv(input logic w, b, r, bp, eb, d, bz, input logic [2:0] l);
    return {w, b, r, bp, eb, d, bz, l};
  endfunction

  function automatic logic [127:0] pack(input desc_t d);
    logic [31:0] w0, w1, w2, w3;
    w0 = {d.od, d.id, d.ds, d.ss};
    w1 = {2'b0, d.fs, d.os, d.is};
    w2 = {2'b0, d.ow, d.oh, d.iw, d.ih, d.ks};
    w3 = {d.enb, d.bp, 8'b0, d.wcnt, d.kw, d.kh};
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] shp(input desc_t d);
    logic [127:0] r;
    r = '0;
    r[101:0] = {d.ss, d.id, d.is, d.ih, d.iw, d.ds, d.od, d.os, d.oh, d.ow, d.fs, d.ks, d.kh, d.kw};
    return r;
  endfunction

  function automatic logic [127:0] shape_obs();
    logic [127:0] r;
    r = '0;
    r[101:0] = {ss, id, is, ih, iw, ds, od, os, oh, ow, fs, ks, kh, kw};
    return r;
  endfunction

  // Reference sequence of output vectors for one layer.
  task automatic push_layer(input logic [2:0] l, input desc_t d, input bit last);
    exp_q.push_back(mv(0, 0, 0, 0, 0, 0, 1, l));
    if (d.wcnt != 0) begin
      exp_q.push_back(mv(1, 0, 0, 0, 0, 0, 1, l));
      exp_q.push_back(mv(0, 0, 0, 0, 0, 0, 1, l));
    end
    if (d.enb) begin
      exp_q.push_back(mv(0, 1, 0, 0, 0, 0, 1, l));
      exp_q.push_back(mv(0, 0, 0, 0, 0, 0, 1, l));
    end
    exp_q.push_back(mv(0, 0, 1, d.bp, d.enb, 0, 1, l));
    if (last) begin
      exp_q.push_back(mv(0, 0, 0, 0, 0, 1, 0, l));
      exp_q.push_back(mv(0, 0, 0, 0, 0, 0, 0, l));
    end
  endtask

  always @(negedge clk) begin
    logic [9:0] v;
    v = {wwrite, bwrite, run, backprop, enbias, done, busy, cur_layer};
    if (mon_en && (v !== prev_v)) begin
      if (exp_q.size() == 0) chk("trans_unexpected", v, prev_v);
      else chk("trans", v, exp_q.pop_front());
      prev_v = v;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_desc(input logic [2:0] l, input desc_t d);
    logic [127:0] p;
    p = pack(d);
    for (int k = 0; k < 4; k++) begin
      cfg_we = 1'b1;
      cfg_addr = {l, k[1:0]};
      cfg_wdata = p[k*32 +: 32];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic wait_hi(input string tag, input int sel, input int budget);
    logic s;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      s = (sel == 0) ? wwrite : (sel == 1) ? bwrite : run;
      if (s) return;
    end
    chk(tag, s, 1'b1);
  endtask

  task automatic src_beats(input int n);
    for (int i = 0; i < n; i++) begin
      src_valid = 1'b1;
      src_ready = 1'b1;
      tick();
    end
    src_valid = 1'b0;
    src_ready = 1'b0;
  endtask

  task automatic dst_end();
    dst_valid = 1'b1;
    dst_ready = 1'b1;
    dst_last = 1'b1;
    tick();
    dst_valid = 1'b0;
    dst_ready = 1'b0;
    dst_last = 1'b0;
  endtask

  task automatic launch(input logic [3:0] n);
    num_layers = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, run count %0d", n_run);
    $fatal(1);
  end

  initial begin
    logic [127:0] p;
    L0 = '{ss:12'h123, id:4'h5, is:10'h2a5, ih:5'd17, iw:5'd9, ds:12'habc, od:4'h9,
           os:10'h155, oh:5'd3, ow:5'd30, fs:10'h3c1, ks:10'h07e, kh:5'd21, kw:5'd12,
           wcnt:12'd3, enb:1'b0, bp:1'b1};
    L1 = '{ss:12'hf0e, id:4'ha, is:10'h0c3, ih:5'd4, iw:5'd27, ds:12'h567, od:4'h3,
           os:10'h2aa, oh:5'd19, ow:5'd1, fs:10'h11f, ks:10'h300, kh:5'd8, kw:5'd31,
           wcnt:12'd0, enb:1'b1, bp:1'b0};
    L0b = L0;
    L0b.wcnt = 12'd0;
    L0b.enb = 1'b1;
    L0b.bp = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_modes", {wwrite, bwrite, run, backprop, enbias, done, busy, cfg_err}, 8'h00);
    chk("rst_shape", shape_obs(), 128'h0);
    chk("rst_layer", cur_layer, 3'd0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // One layer, three weight beats with stalls, no bias.
    write_desc(3'd0, L0);
    push_layer(3'd0, L0, 1'b1);
    launch(4'd1);
    wait_hi("s1_wwrite_rise", 0, 10);
    tick();
    chk("s1_shape", shape_obs(), shp(L0));
    src_valid = 1'b1; src_ready = 1'b0; tick(); tick();
    src_ready = 1'b1; tick();
    src_ready = 1'b0; tick();
    src_ready = 1'b1; tick();
    src_valid = 1'b0; src_ready = 1'b0;
    @(negedge clk);
    chk("s1_wwrite_hold", wwrite, 1'b1);
    tick();
    src_beats(1);
    @(negedge clk);
    chk("s1_wwrite_end", wwrite, 1'b0);
    wait_hi("s1_run_rise", 2, 10);
    tick();
    dst_valid = 1'b1; dst_ready = 1'b1; tick();
    dst_ready = 1'b0; dst_last = 1'b1; tick();
    @(negedge clk);
    chk("s1_run_hold", run, 1'b1);
    tick();
    dst_end();
    @(negedge clk);
    chk("s1_done", done, 1'b1);
    chk("s1_busy_fin", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("s1_sb_empty", exp_q.size(), 0);

    // Two layers; second layer is bias-only. Illegal write while busy.
    tick();
    write_desc(3'd1, L1);
    push_layer(3'd0, L0, 1'b0);
    push_layer(3'd1, L1, 1'b1);
    launch(4'd2);
    wait_hi("s2_wwrite_rise", 0, 10);
    tick();
    src_beats(3);
    wait_hi("s2_run0_rise", 2, 10);
    tick();
    p = pack(L0);
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = ~p[31:0];
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("s2_cfg_err", cfg_err, 1'b1);
    tick();
    @(negedge clk);
    chk("s2_cfg_err_pulse", cfg_err, 1'b0);
    tick();
    dst_end();
    wait_hi("s2_bwrite_rise", 1, 10);
    tick();
    chk("s2_shape_l1", shape_obs(), shp(L1));
    chk("s2_layer", cur_layer, 3'd1);
    src_beats(15);
    @(negedge clk);
    chk("s2_bwrite_hold", bwrite, 1'b1);
    tick();
    src_beats(1);
    @(negedge clk);
    chk("s2_bwrite_end", bwrite, 1'b0);
    wait_hi("s2_run1_rise", 2, 10);
    tick();
    chk("s2_enbias", enbias, 1'b1);
    dst_end();
    @(negedge clk);
    chk("s2_done", done, 1'b1);
    repeat (3) @(negedge clk);
    chk("s2_shape_hold", shape_obs(), shp(L1));
    chk("s2_sb_empty", exp_q.size(), 0);

    // num_layers=0 runs one layer; table unaffected by the dropped write; start while busy ignored.
    tick();
    push_layer(3'd0, L0, 1'b1);
    launch(4'd0);
    wait_hi("s3_wwrite_rise", 0, 10);
    tick();
    chk("s3_readback", shape_obs(), shp(L0));
    launch(4'd2);
    num_layers = 4'd0;
    src_beats(3);
    wait_hi("s3_run_rise", 2, 10);
    tick();
    dst_end();
    @(negedge clk);
    chk("s3_done_nl0", done, 1'b1);
    repeat (3) @(negedge clk);
    chk("s3_sb_empty", exp_q.size(), 0);

    // Descriptor write in the start cycle, then abort on bias beat 7.
    tick();
    exp_q.push_back(mv(0, 0, 0, 0, 0, 0, 1, 3'd0));
    exp_q.push_back(mv(0, 1, 0, 0, 0, 0, 1, 3'd0));
    exp_q.push_back(mv(0, 0, 0, 0, 0, 0, 0, 3'd0));
    p = pack(L0b);
    cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = p[127:96];
    launch(4'd1);
    cfg_we = 1'b0;
    wait_hi("s4_bwrite_rise", 1, 10);
    tick();
    src_beats(6);
    src_valid = 1'b1; src_ready = 1'b1; abort = 1'b1;
    tick();
    src_valid = 1'b0; src_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("s4_abort_bwrite", bwrite, 1'b0);
    chk("s4_abort_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    chk("s4_sb_empty", exp_q.size(), 0);
    tick();
    push_layer(3'd0, L0b, 1'b1);
    launch(4'd1);
    wait_hi("s4_restart_bwrite", 1, 10);
    tick();
    src_beats(16);
    wait_hi("s4_restart_run", 2, 10);
    tick();
    chk("s4_restart_enbias", enbias, 1'b1);

    // Asynchronous reset mid-run.
    exp_q.delete();
    exp_q.push_back(mv(0, 0, 0, 0, 0, 0, 0, 3'd0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_modes", {wwrite, bwrite, run, backprop, enbias, done, busy}, 7'h00);
    chk("s5_async_shape", shape_obs(), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("s5_no_resume", {wwrite, bwrite, run, busy}, 4'h0);
    chk("s5_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
